mas_seq: RTL and testbench

Streaming modular add/sub sequencer built around the team's two-input modular add/sub step. It accepts a burst of operands over a valid/ready handshake and folds each beat into an accumulator modulo Q. It presents one 4-bit residue per burst on an output handshake. It sits between an operand source (testbench or host FSM) and any consumer of MAS results, replacing per-pair combinational use with a sequenced, multi-operand reduction.

---
 rtl/mas_pkg.sv | 23 ++
 rtl/mas_step.sv | 41 ++++
 rtl/mas_seq.sv | 138 +++++++++++++
 tb/tb_mas_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mas_pkg.sv
// Shared definitions for the modular add/sub sequencer and its step unit.
package mas_pkg;

    // Operand width (signed) and residue width.
    localparam int DW = 5;
    localparam int RW = 4;

    // Legal modulus range. Anything outside it poisons the whole burst.
    localparam int Q_MIN = 1;
    localparam int Q_MAX = 15;

    // Operation codes. Codes with bit 1 set are reserved and behave as add.
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    // Sequencer states.
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

endpackage

// File: rtl/mas_step.sv
// Combinational modular add/sub step: res = (acc +/- d) mod q with a single
// correction, plus a flag for an illegal modulus or out-of-range operand.
module mas_step
    import mas_pkg::*;
(
    input  logic [RW-1:0]        acc,
    input  logic signed [DW-1:0] d,
    input  logic [1:0]           op,
    input  logic signed [DW-1:0] q,
    output logic [RW-1:0]        res,
    output logic                 range_err
);

    localparam logic signed [DW:0] QMIN_S = (DW+1)'(Q_MIN);
    localparam logic signed [DW:0] QMAX_S = (DW+1)'(Q_MAX);
    localparam logic signed [DW:0] ZERO_S = '0;

    logic signed [DW:0] acc_s;
    logic signed [DW:0] d_s;
    logic signed [DW:0] q_s;
    logic signed [DW:0] t;

    // Widen to one extra bit so the raw sum/difference cannot wrap, then fold
    // back into 0..q-1. Legal inputs keep t inside (-q, 2q), so one fix suffices.
    always_comb begin
        acc_s = {2'b00, acc};
        d_s   = {d[DW-1], d};
        q_s   = {q[DW-1], q};
        t     = (op == OP_SUB) ? (acc_s - d_s) : (acc_s + d_s);
        if (t >= q_s) begin
            res = RW'(t - q_s);
        end else if (t < ZERO_S) begin
            res = RW'(t + q_s);
        end else begin
            res = RW'(t);
        end
        range_err = (q_s < QMIN_S) || (q_s > QMAX_S) ||
                    (d_s < ZERO_S) || (d_s >= q_s);
    end

endmodule

// File: rtl/mas_seq.sv
// Streaming modular add/sub sequencer: folds a burst of operand beats into a
// residue modulo Q and presents one result per burst on an output handshake.
module mas_seq
    import mas_pkg::*;
#(
    parameter  int N_MAX = 8,
    localparam int CW    = $clog2(N_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [1:0]           in_op,
    input  logic signed [DW-1:0] in_data,
    input  logic signed [DW-1:0] Q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RW-1:0]        out_data,
    output logic [CW-1:0]        out_count,
    output logic                 out_err
);

    state_t               state;
    logic [RW-1:0]        acc;
    logic signed [DW-1:0] q_r;
    logic [CW-1:0]        cnt;
    logic                 err;

    logic                 accept;
    logic                 start;
    logic                 abort;
    logic                 beat;
    logic                 overflow;
    logic                 finish;

    logic [RW-1:0]        step_acc;
    logic [1:0]           step_op;
    logic signed [DW-1:0] step_q;
    logic [RW-1:0]        step_res;
    logic                 step_err;

    logic [RW-1:0]        acc_nxt;
    logic [CW-1:0]        cnt_nxt;
    logic                 err_nxt;

    // Classify the current beat. A first beat reuses the step unit as 0 + d
    // against the incoming Q, which yields d and checks it in one place.
    always_comb begin
        accept   = in_valid && in_ready;
        start    = accept && in_first && (state != S_DONE);
        abort    = start && (state == S_ACCUM);
        beat     = accept && !in_first && (state == S_ACCUM);
        overflow = beat && (cnt == CW'(N_MAX)) && !in_last;
        finish   = (start || beat) && (in_last || overflow);
        step_acc = start ? '0 : acc;
        step_op  = start ? OP_ADD : in_op;
        step_q   = start ? Q : q_r;
    end

    mas_step u_step (
        .acc       (step_acc),
        .d         (in_data),
        .op        (step_op),
        .q         (step_q),
        .res       (step_res),
        .range_err (step_err)
    );

    // Next accumulator, count and sticky error. Illegal operands and the
    // overflow beat are counted but leave the accumulator untouched.
    always_comb begin
        acc_nxt = acc;
        cnt_nxt = cnt;
        err_nxt = err;
        if (start) begin
            acc_nxt = step_err ? '0 : step_res;
            cnt_nxt = CW'(1);
            err_nxt = step_err || abort;
        end else if (beat) begin
            acc_nxt = (step_err || overflow) ? acc : step_res;
            cnt_nxt = cnt + CW'(1);
            err_nxt = err || step_err || overflow || in_op[1];
        end
    end

    // Sequencer FSM with registered handshake and result outputs; results are
    // captured only on entry into DONE and held until the consumer takes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            q_r       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
        end else begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            err <= err_nxt;
            if (start) begin
                q_r <= Q;
            end
            case (state)
                S_IDLE, S_ACCUM: begin
                    if (finish) begin
                        state     <= S_DONE;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= acc_nxt;
                        out_count <= cnt_nxt;
                        out_err   <= err_nxt;
                    end else if (start) begin
                        state <= S_ACCUM;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mas_seq.sv
// Self-checking bench for mas_seq: directed scenarios followed by random
// traffic, all judged against a behavioural burst model.
module tb_mas_seq;

    localparam int N_MAX = 8;
    localparam int CW    = $clog2(N_MAX + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_first;
    logic              in_last;
    logic [1:0]        in_op;
    logic signed [4:0] in_data;
    logic signed [4:0] q_in;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_data;
    logic [CW-1:0]     out_count;
    logic              out_err;

    mas_seq #(.N_MAX(N_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_op     (in_op),
        .in_data   (in_data),
        .Q         (q_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: burst bookkeeping in plain integers.
    bit m_busy, m_done, m_err, e_err;
    int m_q, m_acc, m_cnt, e_data, e_count;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_busy = 0; m_done = 0; m_err = 0;
        m_q = 0; m_acc = 0; m_cnt = 0;
        e_data = 0; e_count = 0; e_err = 0;
    endtask

    task automatic modelFinish();
        m_done  = 1;
        m_busy  = 0;
        e_data  = m_acc;
        e_count = m_cnt;
        e_err   = m_err;
    endtask

    task automatic modelBeat(input bit f, input bit l, input logic [1:0] op,
                             input int d, input int q);
        int t;
        if (f) begin
            m_err  = m_busy;
            m_busy = 1;
            m_q    = q;
            m_cnt  = 1;
            m_acc  = 0;
            if (q < 1 || q > 15) m_err = 1;
            else if (d < 0 || d >= q) m_err = 1;
            else m_acc = d;
            if (l) modelFinish();
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt > N_MAX && !l) begin
                m_err = 1;
                modelFinish();
            end else begin
                if (op[1]) m_err = 1;
                if (m_q < 1 || d < 0 || d >= m_q) begin
                    m_err = 1;
                end else begin
                    t     = (op == 2'b01) ? (m_acc - d) : (m_acc + d);
                    m_acc = ((t % m_q) + m_q) % m_q;
                end
                if (l) modelFinish();
            end
        end
    endtask

    // One clock of stimulus: drive, advance model across the edge, check.
    task automatic applyStimulus(input bit v, input bit f, input bit l,
                                 input logic [1:0] op, input int d, input int q,
                                 input bit ordy);
        bit take_beat, take_out;
        in_valid  = v;
        in_first  = f;
        in_last   = l;
        in_op     = op;
        in_data   = 5'(d);
        q_in      = 5'(q);
        out_ready = ordy;
        take_beat = v && !m_done;
        take_out  = m_done && ordy;
        checkOutput("in_ready", int'(in_ready), int'(!m_done));
        @(posedge clk);
        #1;
        if (take_out) m_done = 0;
        else if (take_beat) modelBeat(f, l, op, d, q);
        checkOutput("out_valid", int'(out_valid), int'(m_done));
        checkOutput("out_data", int'(out_data), e_data);
        checkOutput("out_count", int'(out_count), e_count);
        checkOutput("out_err", int'(out_err), int'(e_err));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
        checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
        checkOutput({tag, "_out_data"}, int'(out_data), 0);
        checkOutput({tag, "_out_count"}, int'(out_count), 0);
        checkOutput({tag, "_out_err"}, int'(out_err), 0);
    endtask

    initial begin
        bit v, f, l, ordy;
        logic [1:0] op;
        int d, q, qref, r;

        rst = 1'b1; in_valid = 0; in_first = 0; in_last = 0; in_op = 2'b00;
        in_data = '0; q_in = '0; out_ready = 0;
        modelReset();
        #2;
        checkResetOutputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic chain, Q=7: 5 + 4 - 6 = 3.
        applyStimulus(1, 1, 0, 2'b00, 5, 7, 0);
        applyStimulus(1, 0, 0, 2'b00, 4, 7, 0);
        applyStimulus(1, 0, 1, 2'b01, 6, 7, 0);
        checkOutput("basic_valid", int'(out_valid), 1);
        checkOutput("basic_data", int'(out_data), 3);
        checkOutput("basic_count", int'(out_count), 3);
        checkOutput("basic_err", int'(out_err), 0);
        applyStimulus(0, 0, 0, 2'b00, 0, 7, 1);

        // Single-beat burst, Q=11.
        applyStimulus(1, 1, 1, 2'b00, 10, 11, 1);
        checkOutput("single_data", int'(out_data), 10);
        checkOutput("single_count", int'(out_count), 1);
        applyStimulus(0, 0, 0, 2'b00, 0, 11, 1);

        // Illegal operand inside a Q=7 burst.
        applyStimulus(1, 1, 0, 2'b00, 2, 7, 0);
        applyStimulus(1, 0, 0, 2'b00, 9, 7, 0);
        applyStimulus(1, 0, 1, 2'b00, 3, 7, 0);
        checkOutput("illegal_data", int'(out_data), 5);
        checkOutput("illegal_count", int'(out_count), 3);
        checkOutput("illegal_err", int'(out_err), 1);
        applyStimulus(0, 0, 0, 2'b00, 0, 7, 1);

        // Q=0 burst.
        applyStimulus(1, 1, 1, 2'b00, 3, 0, 0);
        checkOutput("q0_data", int'(out_data), 0);
        checkOutput("q0_err", int'(out_err), 1);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 1);

        // Overflow: nine add-1 beats, Q=5, never last.
        applyStimulus(1, 1, 0, 2'b00, 1, 5, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 2'b00, 1, 5, 0);
        checkOutput("ovf_valid", int'(out_valid), 1);
        checkOutput("ovf_data", int'(out_data), 3);
        checkOutput("ovf_count", int'(out_count), 9);
        checkOutput("ovf_err", int'(out_err), 1);
        applyStimulus(0, 0, 0, 2'b00, 0, 5, 1);

        // Stray beat in IDLE is dropped.
        applyStimulus(1, 0, 1, 2'b00, 2, 7, 0);
        checkOutput("stray_valid", int'(out_valid), 0);

        // Abort mid-burst, then hold the result under backpressure.
        applyStimulus(1, 1, 0, 2'b00, 3, 7, 0);
        applyStimulus(1, 0, 0, 2'b00, 2, 7, 0);
        applyStimulus(1, 1, 0, 2'b00, 4, 9, 0);
        applyStimulus(1, 0, 1, 2'b00, 3, 9, 0);
        checkOutput("abort_data", int'(out_data), 7);
        checkOutput("abort_count", int'(out_count), 2);
        checkOutput("abort_err", int'(out_err), 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 1, 2'b00, 1, 7, 0);
            checkOutput("bp_in_ready", int'(in_ready), 0);
            checkOutput("bp_data", int'(out_data), 7);
        end
        applyStimulus(0, 0, 0, 2'b00, 0, 7, 1);
        checkOutput("bp_release_valid", int'(out_valid), 0);
        checkOutput("bp_release_ready", int'(in_ready), 1);

        // Async reset between edges while accumulating.
        applyStimulus(1, 1, 0, 2'b00, 6, 13, 0);
        applyStimulus(1, 0, 0, 2'b00, 5, 13, 0);
        #3 rst = 1'b1;
        #1;
        modelReset();
        checkResetOutputs("async");
        #1 rst = 1'b0;
        applyStimulus(1, 1, 0, 2'b00, 12, 13, 0);
        applyStimulus(1, 0, 1, 2'b00, 3, 13, 0);
        checkOutput("post_rst_data", int'(out_data), 2);
        checkOutput("post_rst_count", int'(out_count), 2);
        checkOutput("post_rst_err", int'(out_err), 0);
        applyStimulus(0, 0, 0, 2'b00, 0, 13, 1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 9) < 8);
            f = m_busy ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 7);
            l = f ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 9));
            if (r < 5) op = 2'b00;
            else if (r < 9) op = 2'b01;
            else op = 2'(2 + $urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) q = int'($urandom_range(0, 16)) - 16;
            else q = int'($urandom_range(1, 15));
            qref = f ? q : m_q;
            if (qref >= 1 && $urandom_range(0, 9) < 9) d = int'($urandom_range(0, qref - 1));
            else d = int'($urandom_range(0, 31)) - 16;
            ordy = ($urandom_range(0, 9) < 6);
            applyStimulus(v, f, l, op, d, q, ordy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
